// File: rtl/seg_pkg.sv
// Shared constants and helpers for the multiplexed seven-segment scan driver.
package seg_pkg;

  localparam int         NUM_DIGITS = 4;
  localparam logic [6:0] SEG_OFF    = 7'b1111111;
  localparam logic [3:0] ANODE_OFF  = 4'b1111;

  typedef logic [1:0] slot_t;

  // Active-low one-cold anode pattern for the given digit slot.
  function automatic logic [3:0] anode_sel(input slot_t idx);
    anode_sel = ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/seg_scan_driver_tick_gen.sv
// Free-running modulo-DIV counter with a one-cycle pulse on terminal count.
// Dropping en clears the count so a re-enable always starts a full period.
module tick_gen #(
  parameter  int DIV = 8,
  localparam int W   = (DIV > 1) ? $clog2(DIV) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         tick
);

  localparam logic [W-1:0] LAST = W'(DIV - 1);

  assign tick = en && (count == LAST);

  // Count 0..DIV-1 while enabled, hold at zero while disabled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (!en) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed seven-segment scan driver with per-digit blinking
// and a blanking guard at the start of every digit slot.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int SCAN_DIV   = 100000,
  parameter int GUARD      = 16,
  parameter int BLINK_HALF = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] dig0,
  input  logic [6:0] dig1,
  input  logic [6:0] dig2,
  input  logic [6:0] dig3,
  input  logic       blink_en,
  input  logic [3:0] blink_mask,
  output logic [3:0] anodes,
  output logic [6:0] segments,
  output logic [1:0] slot_idx
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  logic [SW-1:0] slot_cnt;
  logic          slot_tick;
  logic [BW-1:0] blink_cnt_unused;
  logic          blink_tick;
  logic          blink_phase;
  logic          in_guard;
  logic [6:0]    dig_sel;
  logic [3:0]    anodes_p0;
  logic [6:0]    segments_p0;

  tick_gen #(.DIV(SCAN_DIV)) u_slot_tick (
    .clk   (clk),
    .rst   (rst),
    .en    (1'b1),
    .count (slot_cnt),
    .tick  (slot_tick)
  );

  tick_gen #(.DIV(BLINK_HALF)) u_blink_tick (
    .clk   (clk),
    .rst   (rst),
    .en    (blink_en),
    .count (blink_cnt_unused),
    .tick  (blink_tick)
  );

  // Guard window covers the first GUARD counts of each slot; none when GUARD is 0.
  if (GUARD == 0) begin : g_no_guard
    assign in_guard = 1'b0;
  end else begin : g_guard
    localparam logic [SW-1:0] GUARD_V = SW'(GUARD);
    assign in_guard = (slot_cnt < GUARD_V);
  end

  // Advance to the next digit each time the slot counter wraps.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_idx <= '0;
    end else if (slot_tick) begin
      slot_idx <= slot_idx + 2'd1;
    end
  end

  // Blink phase toggles per half-period and is forced visible while disabled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blink_phase <= 1'b0;
    end else if (!blink_en) begin
      blink_phase <= 1'b0;
    end else if (blink_tick) begin
      blink_phase <= ~blink_phase;
    end
  end

  // Pick the live digit pattern for the current slot (no per-slot latching).
  always_comb begin
    dig_sel = SEG_OFF;
    case (slot_idx)
      2'd0:    dig_sel = dig0;
      2'd1:    dig_sel = dig1;
      2'd2:    dig_sel = dig2;
      default: dig_sel = dig3;
    endcase
  end

  // p0: next anode/segment drive from slot state, blink state and digit inputs.
  always_comb begin
    anodes_p0   = ANODE_OFF;
    segments_p0 = SEG_OFF;
    if (!in_guard) begin
      anodes_p0 = anode_sel(slot_idx);
      if (!(blink_en && blink_phase && blink_mask[slot_idx])) begin
        segments_p0 = dig_sel;
      end
    end
  end

  // p1: registered pad drive; reset blanks the display without a clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      anodes   <= ANODE_OFF;
      segments <= SEG_OFF;
    end else begin
      anodes   <= anodes_p0;
      segments <= segments_p0;
    end
  end

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 100000; clk cycles per digit slot, giving 1 kHz per digit at 100 MHz.
REQ-002 SHALL have parameter GUARD, default 16; anode-off cycles at the start of each slot, with 0 <= GUARD < SCAN_DIV.
REQ-003 SHALL have parameter BLINK_HALF, default 25000000; clk cycles per blink half-period.
REQ-004 SHALL have port clk, input, 1 bit: system clock, rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have ports dig0, dig1, dig2, dig3, input, 7 bits each: active-low segment patterns, dig0 leftmost.
REQ-007 SHALL have port blink_en, input, 1 bit: enables blinking of masked digits.
REQ-008 SHALL have port blink_mask, input, 4 bits: bit i selects digit i for blinking.
REQ-009 SHALL have port anodes, output, 4 bits: active-low digit enables, registered.
REQ-010 SHALL have port segments, output, 7 bits: active-low segment drive, registered.
REQ-011 SHALL have port slot_idx, output, 2 bits: current digit index, for debug and bench use.

Function
REQ-012 Slot counter SHALL count 0..SCAN_DIV-1 and wrap.
- On wrap, slot_idx SHALL advance 0->1->2->3->0.
REQ-013 Guard interval: while slot counter < GUARD, the next anodes SHALL be 4'b1111 and the next segments 7'b1111111.
REQ-014 Outside the guard interval, the next anodes SHALL be low only at bit slot_idx (idx0 -> 4'b1110, idx3 -> 4'b0111).
- The next segments SHALL be dig[slot_idx].
REQ-015 Outputs SHALL be registered, with 1-cycle latency from slot counter/slot_idx/dig inputs to anodes/segments.
- dig inputs SHALL be sampled every cycle, with no slot latching.
REQ-016 Blink counter SHALL count 0..BLINK_HALF-1; on wrap it SHALL toggle blink_phase.
REQ-017 While blink_en=0, blink counter and blink_phase SHALL be held at 0.
- Re-asserting blink_en SHALL therefore always start with the visible phase.
REQ-018 When blink_en=1, blink_phase=1 and blink_mask[slot_idx]=1, the next segments SHALL be 7'b1111111.
- Anodes SHALL still follow REQ-013 and REQ-014.
REQ-019 If blink_mask changes mid-slot, the change SHALL take effect on the next cycle's output register, without waiting for a slot boundary.
REQ-020 A slot-counter wrap and a blink-counter wrap in the same cycle SHALL both take effect independently in that cycle.
REQ-021 At most one anode bit SHALL be low in any cycle.

Reset
REQ-022 When rst=0, the block SHALL asynchronously clear:
- slot counter = 0
- slot_idx = 0
- blink counter = 0
- blink_phase = 0
- anodes = 4'b1111
- segments = 7'b1111111
REQ-023 On the first rising clk edge after rst deasserts, the block SHALL begin slot 0 at slot counter 0, with the guard interval applied.
REQ-024 Reset asserted mid-slot SHALL blank the display immediately, without waiting for a clock edge.

Structure
REQ-025 Package seg_pkg SHALL hold the shared constants:
- SEG_OFF = 7'b1111111
- ANODE_OFF = 4'b1111
- NUM_DIGITS = 4
REQ-026 One sub-module tick_gen (parameter DIV, 1-cycle pulse on terminal count, enable input, asynchronous active-low reset) SHALL be used twice: once for the slot counter, once for the blink counter.
REQ-027 Counter widths SHALL be $clog2(DIV), with no truncation for the default parameters.

Verification
Benches use SCAN_DIV=8, GUARD=2, BLINK_HALF=20.
REQ-028 Reset scenario: assert rst=0 mid-run -> anodes=4'b1111 and segments=7'b1111111 immediately.
- After release: anodes=4'b1111 for 2 cycles (guard), then 4'b1110 for 6 cycles.
REQ-029 Scan order scenario: dig0..dig3 = 7'h01,7'h02,7'h04,7'h08, blink_en=0.
- segments SHALL cycle 01,02,04,08 with anodes 1110,1101,1011,0111.
- Each value SHALL be held 6 cycles, separated by 2-cycle all-off gaps, and repeat every 32 cycles.
REQ-030 Blink scenario: blink_en=1, blink_mask=4'b0011.
- Digits 0 and 1 show 7'h7F during alternate 20-cycle phases.
- Digits 2 and 3 are never blanked.
- Anodes are unaffected.
REQ-031 Blink restart scenario: drop blink_en mid off-phase, then raise it 5 cycles later.
- Masked digits SHALL be visible for a full 20 cycles before the first blank.
REQ-032 Live update scenario: change dig2 from 7'h40 to 7'h79 during slot 2.
- segments SHALL show 7'h79 exactly one cycle later, within the same slot.
REQ-033 Throughout all scenarios, an assertion SHALL check that at most one anode bit is low in every cycle.
